fifo_uart_tx: RTL and testbench

- Read-side consumer of the synchronous FIFO. Drains one word at a time and serialises it as an asynchronous UART frame on a single line.
- Frame format: LSB first, start bit, data, optional parity, stop bits.
- Sits directly downstream of the FIFO: drives its read enable and samples its registered read data.
- Holds off while the FIFO is empty or the block is disabled.

---
 rtl/fifo_uart_tx_pkg.sv | 16 +
 rtl/fifo_uart_tx_baud.sv | 33 +++
 rtl/fifo_uart_tx.sv | 169 ++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_baud.sv
// uart_baud_tick: free-running bit-period divider, held at zero while clr is high.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    tick  = !clr && (cnt_q == CNT_LAST);
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops one FIFO word at a time and sends it as an LSB-first UART frame.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between data and stop bits.
module fifo_uart_tx #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  import fifo_uart_tx_pkg::*;

  localparam int unsigned BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  tx_state_t        state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    bit_q, bit_d;
`ifdef FIFO_UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic baud_clr;
  logic tick;
  logic start_req;

  // Reset also masks the pop request so no word leaves the FIFO while held in reset.
  assign start_req = en && !fifo_empty && !rst;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .clr (baud_clr),
    .tick(tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bit_q    <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // bit_q counts data bits in DATA and is reused to count stop bits in STOP.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_req) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        state_d = LOAD;
      end
      LOAD: begin
        shift_d  = fifo_data;
        bit_d    = '0;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d = ^fifo_data;
`endif
        state_d  = START;
      end
      START: begin
        if (tick) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            state_d = IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    tx         = IDLE_LEVEL;
    fifo_rd_en = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    baud_clr   = 1'b0;
    case (state_q)
      IDLE: begin
        busy       = 1'b0;
        baud_clr   = 1'b1;
        fifo_rd_en = start_req;
      end
      FETCH, LOAD: begin
        baud_clr = 1'b1;
      end
      START: begin
        tx = ~IDLE_LEVEL;
      end
      DATA: begin
        tx = shift_q[0];
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        tx = parity_q;
      end
`endif
      STOP: begin
        frame_done = tick && (bit_q == STOP_LAST);
      end
      default: begin
        tx = IDLE_LEVEL;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed self-checking bench for fifo_uart_tx with a small behavioural FIFO on its read side.
module tb_fifo_uart_tx;

  localparam int CPB = 16;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int FLEN = (1 + 8 + 1 + 1) * CPB;
`else
  localparam int FLEN = (1 + 8 + 1) * CPB;
`endif

  logic       clk;
  logic       rst;
  logic       en;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] fifo_data;
  logic       tx;
  logic       busy;
  logic       frame_done;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [32];
  int wr_ptr = 0;
  int rd_ptr = 0;
  logic rd_seen = 1'b0;

  int cyc = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int bad_rd = 0;
  int last_rd_cyc = -1;

  fifo_uart_tx #(
    .WIDTH(8),
    .CLKS_PER_BIT(CPB),
    .STOP_BITS(1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .fifo_data (fifo_data),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(negedge clk) begin
    cyc++;
    rd_seen = fifo_rd_en;
    if (fifo_rd_en === 1'b1) begin
      rd_cnt++;
      last_rd_cyc = cyc;
      if (fifo_empty) bad_rd++;
    end
    if (frame_done === 1'b1) done_cnt++;
  end

  always @(posedge clk) begin
    if (rd_seen === 1'b1) begin
      fifo_data <= mem[rd_ptr % 32];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  function automatic logic exp_tx(input logic [7:0] w, input int c);
    int b;
    b = c / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return w[b-1];
`ifdef FIFO_UART_TX_PARITY_EN
    if (b == 9) return ^w;
`endif
    return 1'b1;
  endfunction

  task automatic push(input logic [7:0] w);
    @(posedge clk);
    #1;
    mem[wr_ptr % 32] = w;
    wr_ptr++;
  endtask

  task automatic wait_fall(output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      #1;
      waited++;
    end while (tx !== 1'b0 && waited < 400);
  endtask

  // Follows one whole frame cycle by cycle from the first start-bit cycle.
  task automatic check_frame(input logic [7:0] w, input string name,
                             output int start_cyc, output int end_cyc);
    int bad, nd, done_at, waited;
    start_cyc = -1;
    end_cyc   = -1;
    wait_fall(waited);
    checks++;
    if (tx !== 1'b0) begin
      errors++;
      $display("FAIL %s_start: tx=%b after %0d cycles, required 0", name, tx, waited);
      return;
    end
    start_cyc = cyc;
    bad = 0; nd = 0; done_at = -1;
    for (int c = 0; c < FLEN; c++) begin
      if (c > 0) begin
        @(negedge clk);
        #1;
      end
      if (tx !== exp_tx(w, c) || busy !== 1'b1) begin
        if (bad == 0)
          $display("FAIL %s_bits: cycle %0d tx=%b busy=%b, required tx=%b busy=1",
                   name, c, tx, busy, exp_tx(w, c));
        bad++;
      end
      if (frame_done === 1'b1) begin
        nd++;
        done_at = c;
      end
    end
    end_cyc = cyc;
    checks++;
    if (bad != 0) errors++;
    checks++;
    if (nd != 1 || done_at != FLEN - 1) begin
      errors++;
      $display("FAIL %s_done: pulses=%0d at cycle %0d, required 1 at %0d", name, nd, done_at, FLEN - 1);
    end
    @(negedge clk);
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_tail: tx=%b busy=%b, required tx=1 busy=0", name, tx, busy);
    end
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1;
    en  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: tx=%b busy=%b rd_en=%b done=%b, required 1 0 0 0",
               tx, busy, fifo_rd_en, frame_done);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_empty: %0d cycles with tx!=1 or busy!=0, required 0", bad);
    end
    checks++;
    if (rd_cnt != 0) begin
      errors++;
      $display("FAIL idle_no_read: rd_en pulses=%0d, required 0", rd_cnt);
    end
  endtask

  task automatic test_single();
    int r0, d0, s, e;
    r0 = rd_cnt;
    d0 = done_cnt;
    push(8'hA5);
    check_frame(8'hA5, "a5", s, e);
    // rd_en cycle, then FETCH and LOAD, then the first start-bit cycle.
    checks++;
    if (s - last_rd_cyc != 3) begin
      errors++;
      $display("FAIL a5_latency: start-rd_en=%0d cycles, required 3", s - last_rd_cyc);
    end
    checks++;
    if (rd_cnt - r0 != 1) begin
      errors++;
      $display("FAIL a5_rd_pulses: got %0d, required 1", rd_cnt - r0);
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL a5_done_pulses: got %0d, required 1", done_cnt - d0);
    end
  endtask

  task automatic test_back_to_back();
    int r0, d0, s1, e1, s2, e2, s3, e3;
    r0 = rd_cnt;
    d0 = done_cnt;
    push(8'h01);
    push(8'hFF);
    push(8'h80);
    check_frame(8'h01, "b2b_01", s1, e1);
    check_frame(8'hFF, "b2b_ff", s2, e2);
    check_frame(8'h80, "b2b_80", s3, e3);
    // Last stop cycle, then IDLE, FETCH, LOAD, then start.
    checks++;
    if (s2 - e1 != 4) begin
      errors++;
      $display("FAIL b2b_gap1: start-stop_end=%0d, required 4", s2 - e1);
    end
    checks++;
    if (s3 - e2 != 4) begin
      errors++;
      $display("FAIL b2b_gap2: start-stop_end=%0d, required 4", s3 - e2);
    end
    repeat (50) @(negedge clk);
    #1;
    checks++;
    if (rd_cnt - r0 != 3) begin
      errors++;
      $display("FAIL b2b_rd_pulses: got %0d, required 3", rd_cnt - r0);
    end
    checks++;
    if (done_cnt - d0 != 3) begin
      errors++;
      $display("FAIL b2b_done_pulses: got %0d, required 3", done_cnt - d0);
    end
  endtask

  task automatic test_en_drop();
    int r0, d0, s, e, w;
    r0 = rd_cnt;
    d0 = done_cnt;
    push(8'h3C);
    push(8'h11);
    push(8'h22);
    fork
      check_frame(8'h3C, "endrop_3c", s, e);
      begin
        wait_fall(w);
        repeat (70) @(posedge clk);
        #1;
        en = 1'b0;
      end
    join
    repeat (300) @(negedge clk);
    #1;
    checks++;
    if (rd_cnt - r0 != 1 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL endrop_hold: rd=%0d done=%0d, required rd=1 done=1", rd_cnt - r0, done_cnt - d0);
    end
    @(posedge clk);
    #1;
    en = 1'b1;
    check_frame(8'h11, "endrop_11", s, e);
    check_frame(8'h22, "endrop_22", s, e);
    checks++;
    if (rd_cnt - r0 != 3) begin
      errors++;
      $display("FAIL endrop_resume: rd pulses=%0d, required 3", rd_cnt - r0);
    end
  endtask

  task automatic test_mid_reset();
    int r0, d0, s, e, w;
    r0 = rd_cnt;
    d0 = done_cnt;
    push(8'h55);
    push(8'h66);
    wait_fall(w);
    repeat (100) @(posedge clk);
    #1;
    en  = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state: tx=%b busy=%b rd_en=%b, required 1 0 0", tx, busy, fifo_rd_en);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    en  = 1'b1;
    check_frame(8'h66, "midrst_66", s, e);
    checks++;
    if (rd_cnt - r0 != 2 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL midrst_counts: rd=%0d done=%0d, required rd=2 done=1", rd_cnt - r0, done_cnt - d0);
    end
  endtask

`ifdef FIFO_UART_TX_PARITY_EN
  task automatic test_parity();
    int s, e;
    push(8'h07);
    push(8'h03);
    check_frame(8'h07, "par_07", s, e);
    check_frame(8'h03, "par_03", s, e);
  endtask
`endif

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    fifo_data = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_en_drop();
    test_mid_reset();
`ifdef FIFO_UART_TX_PARITY_EN
    test_parity();
`endif
    checks++;
    if (bad_rd != 0) begin
      errors++;
      $display("FAIL underflow_read: rd_en while empty %0d times, required 0", bad_rd);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
